// File: rtl/alu_issue_queue_if.sv
// Request/response handshake bundle between decode, the ALU issue queue and writeback.
interface alu_issue_queue_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [3:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic             out_zero;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_a, in_b, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_illegal, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_illegal, out_tag
   );
endinterface

// File: rtl/alu_issue_queue.sv
// FIFO-buffered issue stage feeding an external combinational ALU, with a
// registered valid/ready result stage toward writeback.
module alu_issue_queue #(
   parameter  int DEPTH = 4,
   parameter  int TAG_W = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   alu_issue_queue_if.slave  bus,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [3:0]        alu_op,
   input  logic [31:0]       alu_result,
   input  logic              alu_zero,
   output logic [CNT_W-1:0]  count
);

   typedef struct packed {
      logic [31:0]      a;
      logic [31:0]      b;
      logic [3:0]       op;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_result_q, out_result_d;
   logic             out_zero_q, out_zero_d;
   logic             out_illegal_q, out_illegal_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;

   logic   in_ready;
   logic   push;
   logic   adv;
   logic   nonempty;
   entry_t head;

   always_comb begin
      // A full queue refuses new work even if the head retires this cycle.
      in_ready = !rst && (count_q < CNT_W'(DEPTH));
      push     = bus.in_valid && in_ready;
      nonempty = (count_q != '0);
      head     = mem_q[rd_ptr_q];
      adv      = nonempty && (!out_valid_q || bus.out_ready);

      alu_a  = nonempty ? head.a  : '0;
      alu_b  = nonempty ? head.b  : '0;
      alu_op = nonempty ? head.op : '0;

      mem_d         = mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      out_valid_d   = out_valid_q;
      out_result_d  = out_result_q;
      out_zero_d    = out_zero_q;
      out_illegal_d = out_illegal_q;
      out_tag_d     = out_tag_q;

      if (push) begin
         mem_d[wr_ptr_q] = '{a: bus.in_a, b: bus.in_b, op: bus.in_op, tag: bus.in_tag};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      // The ALU output for the head is captured in the same cycle it is dequeued.
      if (adv) begin
         out_valid_d   = 1'b1;
         out_result_d  = alu_result;
         out_zero_d    = alu_zero;
         out_illegal_d = (head.op > 4'd8);
         out_tag_d     = head.tag;
         rd_ptr_d      = rd_ptr_q + PTR_W'(1);
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      count_d = count_q + CNT_W'(push) - CNT_W'(adv);
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_zero_q    <= 1'b0;
         out_illegal_q <= 1'b0;
         out_tag_q     <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_zero_q    <= out_zero_d;
         out_illegal_q <= out_illegal_d;
         out_tag_q     <= out_tag_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_result  = out_result_q;
   assign bus.out_zero    = out_zero_q;
   assign bus.out_illegal = out_illegal_q;
   assign bus.out_tag     = out_tag_q;
   assign count           = count_q;

endmodule
